sweep_dds: RTL and testbench



---
 rtl/sweep_dds.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_sweep_dds.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_dds.sv
// sweep_dds: direct digital synthesiser with linear frequency sweep.
// Quarter-wave sine ROM, registered config handshake, phase-continuous
// retune, one-shot or repeating sweep, post-ROM amplitude scaling and
// a 4-stage output pipeline with a valid flag.
// Optional build macro: DDS_DITHER_EN adds an LFSR dither to the phase
// sum ahead of truncation to spread truncation spurs.
`timescale 1ns/1ps
module sweep_dds #(
    parameter int PW = 32,
    parameter int DW = 12,
    parameter int AW = 12,
    parameter int SW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_mode,
    input  logic [PW-1:0]        cfg_freq,
    input  logic [PW-1:0]        cfg_step,
    input  logic [SW-1:0]        cfg_steps,
    input  logic [PW-1:0]        cfg_phase,
    input  logic [DW-1:0]        cfg_amp,
    input  logic                 stop,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 out_valid,
    output logic signed [DW-1:0] out
);

    localparam int ROM_N   = 2 ** (AW - 2);
    localparam int MAG_MAX = 2 ** (DW - 1) - 1;

    localparam logic [SW-1:0]         CNT_ONE = SW'(1);
    localparam logic signed [2*DW:0]  SAT_HI  = (2*DW+1)'(MAG_MAX);
    localparam logic signed [2*DW:0]  SAT_LO  = -SAT_HI;
    localparam logic signed [2*DW:0]  RND     = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TONE  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Quarter-wave table: entry i = round(sin(pi*(2i+1)/2^AW) * MAG_MAX).
    // Evaluated at elaboration with a Q30 Taylor series; the half-step
    // offset keeps the mirror exact and avoids a zero entry.
    // ------------------------------------------------------------------
    function automatic longint sine_entry(input int i);
        longint x;
        longint term;
        longint acc;
        x    = (64'sd3373259426 * (longint'(i) * 64'sd2 + 64'sd1)) >>> AW;
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = term / ((longint'(k) * 64'sd2) * (longint'(k) * 64'sd2 + 64'sd1));
            if ((k % 2) == 1) begin
                acc = acc - term;
            end else begin
                acc = acc + term;
            end
        end
        return (acc * longint'(MAG_MAX) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic [DW-2:0] rom_tbl [ROM_N];

    for (genvar g = 0; g < ROM_N; g++) begin : g_rom
        localparam logic [DW-2:0] ROM_V = (DW-1)'(sine_entry(g));
        assign rom_tbl[g] = ROM_V;
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t          state_r, state_s;
    logic [PW-1:0]   freq_r, freq_s;
    logic [SW-1:0]   cnt_r, cnt_s;
    logic            done_s;
    logic            sweep_done_r;
    logic            busy_r;
    logic            accept_s;
    logic            cfg_ready_s;
    logic            sweep_mode_s;

    logic [PW-1:0]   step_r;
    logic [PW-1:0]   start_r;
    logic [SW-1:0]   steps_r;
    logic [PW-1:0]   phase_r;
    logic [DW-1:0]   amp_r;
    logic            rpt_r;
    logic [PW-1:0]   phase_acc_r;

    assign cfg_ready_s = !stop && (state_r != ST_SWEEP);
    assign accept_s    = cfg_valid && cfg_ready_s;
    assign cfg_ready   = cfg_ready_s;
    assign busy        = busy_r;
    assign sweep_done  = sweep_done_r;

    // Decode whether the offered mode is a sweep mode
    always_comb begin
        case (cfg_mode)
            2'd1, 2'd2: sweep_mode_s = 1'b1;
            default:    sweep_mode_s = 1'b0;
        endcase
    end

    // Next state, frequency and step counter; stop beats accept beats sweep
    always_comb begin
        state_s = state_r;
        freq_s  = freq_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            freq_s  = '0;
        end else if (accept_s) begin
            freq_s = cfg_freq;
            cnt_s  = cfg_steps;
            if (sweep_mode_s && (cfg_steps != '0)) begin
                state_s = ST_SWEEP;
            end else begin
                state_s = ST_TONE;
            end
        end else if (en && (state_r == ST_SWEEP)) begin
            if (cnt_r == CNT_ONE) begin
                done_s = 1'b1;
                if (rpt_r) begin
                    freq_s = start_r;
                    cnt_s  = steps_r;
                end else begin
                    freq_s  = freq_r + step_r;
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = ST_HOLD;
                end
            end else begin
                freq_s = freq_r + step_r;
                cnt_s  = cnt_r - CNT_ONE;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Control registers and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            freq_r       <= '0;
            cnt_r        <= '0;
            sweep_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            freq_r       <= freq_s;
            cnt_r        <= cnt_s;
            sweep_done_r <= done_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // Capture configuration fields on an accepted handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r  <= '0;
            start_r <= '0;
            steps_r <= '0;
            phase_r <= '0;
            amp_r   <= '0;
            rpt_r   <= 1'b0;
        end else if (accept_s) begin
            step_r  <= cfg_step;
            start_r <= cfg_freq;
            steps_r <= cfg_steps;
            phase_r <= cfg_phase;
            amp_r   <= cfg_amp;
            rpt_r   <= (cfg_mode == 2'd2);
        end
    end

    // Phase accumulator: runs on en outside IDLE, never reset by a retune
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_acc_r <= '0;
        end else if (stop) begin
            phase_acc_r <= '0;
        end else if (en && (state_r != ST_IDLE)) begin
            phase_acc_r <= phase_acc_r + freq_r;
        end
    end

    // ------------------------------------------------------------------
    // Optional phase dither
    // ------------------------------------------------------------------
`ifdef DDS_DITHER_EN
    localparam int LW = PW - AW;

    // Galois feedback masks for maximal-length sequences of common widths
    function automatic logic [LW-1:0] lfsr_mask(input int w);
        logic [31:0] m;
        case (w)
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            10:      m = 32'h0000_0240;
            12:      m = 32'h0000_0829;
            16:      m = 32'h0000_D008;
            20:      m = 32'h0009_0000;
            24:      m = 32'h00E1_0000;
            28:      m = 32'h0900_0000;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0001 | (32'h0000_0001 << (w - 1));
        endcase
        return m[LW-1:0];
    endfunction

    localparam logic [LW-1:0] LFSR_MASK = lfsr_mask(LW);
    localparam logic [LW-1:0] LFSR_SEED = LW'(1);

    logic [LW-1:0] lfsr_r;

    // Dither LFSR steps with the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (en && (state_r != ST_IDLE)) begin
            lfsr_r <= {1'b0, lfsr_r[LW-1:1]} ^ (lfsr_r[0] ? LFSR_MASK : '0);
        end
    end

    logic [AW-1:0] p_s;
    assign p_s = AW'((phase_acc_r + phase_r + {{AW{1'b0}}, lfsr_r}) >> (PW - AW));
`else
    logic [AW-1:0] p_s;
    assign p_s = AW'((phase_acc_r + phase_r) >> (PW - AW));
`endif

    // ------------------------------------------------------------------
    // Output pipeline
    // ------------------------------------------------------------------
    logic [AW-1:0]          p1_r;
    logic                   v1_r;
    logic                   neg2_r;
    logic [DW-2:0]          mag2_r;
    logic                   v2_r;
    logic signed [DW-1:0]   s3_r;
    logic                   v3_r;
    logic signed [DW-1:0]   out_r;
    logic                   out_valid_r;
    logic [AW-3:0]          idx_s;

    logic signed [2*DW:0]   s_ext_s;
    logic signed [2*DW:0]   amp_ext_s;
    logic signed [2*DW:0]   prod_s;
    logic signed [2*DW:0]   sh_s;
    logic signed [DW-1:0]   y_s;

    // Quarter-wave index: odd quadrants read the table mirrored
    always_comb begin
        if (p1_r[AW-2]) begin
            idx_s = ~p1_r[AW-3:0];
        end else begin
            idx_s = p1_r[AW-3:0];
        end
    end

    // Amplitude scale with round-half-up, then symmetric saturation
    always_comb begin
        s_ext_s   = {{(DW+1){s3_r[DW-1]}}, s3_r};
        amp_ext_s = {{(DW+1){1'b0}}, amp_r};
        prod_s    = s_ext_s * amp_ext_s + RND;
        sh_s      = prod_s >>> (DW - 1);
        if (sh_s > SAT_HI) begin
            y_s = SAT_HI[DW-1:0];
        end else if (sh_s < SAT_LO) begin
            y_s = SAT_LO[DW-1:0];
        end else begin
            y_s = sh_s[DW-1:0];
        end
    end

    // Four en-gated stages with a valid bit; stop flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_r        <= '0;
            v1_r        <= 1'b0;
            neg2_r      <= 1'b0;
            mag2_r      <= '0;
            v2_r        <= 1'b0;
            s3_r        <= '0;
            v3_r        <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (stop) begin
            p1_r        <= '0;
            v1_r        <= 1'b0;
            neg2_r      <= 1'b0;
            mag2_r      <= '0;
            v2_r        <= 1'b0;
            s3_r        <= '0;
            v3_r        <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (en) begin
            p1_r        <= p_s;
            v1_r        <= (state_r != ST_IDLE);
            neg2_r      <= p1_r[AW-1];
            mag2_r      <= rom_tbl[idx_s];
            v2_r        <= v1_r;
            s3_r        <= neg2_r ? -$signed({1'b0, mag2_r}) : $signed({1'b0, mag2_r});
            v3_r        <= v2_r;
            out_r       <= v3_r ? y_s : '0;
            out_valid_r <= v3_r;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sweep_dds.sv
// Directed self-checking bench for sweep_dds (default build, no dither).
`timescale 1ns/1ps
module tb_sweep_dds;

    localparam int PW = 32;
    localparam int DW = 12;
    localparam int AW = 12;
    localparam int SW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 cfg_valid;
    logic                 cfg_ready_s;
    logic [1:0]           cfg_mode;
    logic [PW-1:0]        cfg_freq;
    logic [PW-1:0]        cfg_step;
    logic [SW-1:0]        cfg_steps;
    logic [PW-1:0]        cfg_phase;
    logic [DW-1:0]        cfg_amp;
    logic                 stop;
    logic                 busy_s;
    logic                 sweep_done_s;
    logic                 out_valid_s;
    logic signed [DW-1:0] out_s;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt;

    // Expected outputs per quadrant (0,1,2,3) for freq = quarter cycle
    longint tone_q[4] = '{2, 2047, -2, -2047};   // amp = unity
    longint half_q[4] = '{1, 1024, -1, -1023};   // amp = 1/2
    longint sat_q[4]  = '{4, 2047, -4, -2047};   // amp = 4095, saturated

    sweep_dds #(.PW(PW), .DW(DW), .AW(AW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready_s),
        .cfg_mode   (cfg_mode),
        .cfg_freq   (cfg_freq),
        .cfg_step   (cfg_step),
        .cfg_steps  (cfg_steps),
        .cfg_phase  (cfg_phase),
        .cfg_amp    (cfg_amp),
        .stop       (stop),
        .busy       (busy_s),
        .sweep_done (sweep_done_s),
        .out_valid  (out_valid_s),
        .out        (out_s)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input logic [PW-1:0] f, input logic [PW-1:0] st,
                         input logic [SW-1:0] n, input logic [PW-1:0] ph, input logic [DW-1:0] a);
        cfg_mode  = m;
        cfg_freq  = f;
        cfg_step  = st;
        cfg_steps = n;
        cfg_phase = ph;
        cfg_amp   = a;
        cfg_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 2'd0; cfg_freq = '0; cfg_step = '0; cfg_steps = '0;
        cfg_phase = '0; cfg_amp = '0;
        #1;
        check_val("rst_out", out_s, 0);
        check_val("rst_valid", out_valid_s, 0);
        check_val("rst_done", sweep_done_s, 0);
        check_val("rst_busy", busy_s, 0);
        check_val("rst_ready", cfg_ready_s, 1);
        tick(); tick();
        rst = 1'b0;
        en  = 1'b1;

        // Tone at quarter-cycle frequency, unity amplitude
        offer(2'd0, 32'h4000_0000, 32'h0, 16'd0, 32'h0, 12'd2048);
        tick();
        cfg_valid = 1'b0;
        check_val("tone_busy", busy_s, 1);
        check_val("tone_valid0", out_valid_s, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 4) begin
                check_val($sformatf("tone_valid_e%0d", k), out_valid_s, 0);
                check_val($sformatf("tone_out_e%0d", k), out_s, 0);
            end else begin
                check_val($sformatf("tone_valid_e%0d", k), out_valid_s, 1);
                check_val($sformatf("tone_out_e%0d", k), out_s, tone_q[(k - 4) % 4]);
            end
        end

        // amp = 0: valid output of zero
        offer(2'd0, 32'h4000_0000, 32'h0, 16'd0, 32'h0, 12'd0);
        tick();                               // E9, old amp still applied
        cfg_valid = 1'b0;
        check_val("amp0_old", out_s, 2047);
        tick();                               // E10
        check_val("amp0_out", out_s, 0);
        check_val("amp0_valid", out_valid_s, 1);
        tick();                               // E11
        check_val("amp0_out2", out_s, 0);

        // amp = half
        offer(2'd0, 32'h4000_0000, 32'h0, 16'd0, 32'h0, 12'd1024);
        tick();                               // E12
        cfg_valid = 1'b0;
        check_val("half_e12", out_s, 0);
        for (int k = 13; k <= 16; k++) begin
            tick();
            check_val($sformatf("half_e%0d", k), out_s, half_q[(k - 4) % 4]);
        end

        // amp = 4095: saturation at the peaks
        offer(2'd0, 32'h4000_0000, 32'h0, 16'd0, 32'h0, 12'd4095);
        tick();                               // E17
        cfg_valid = 1'b0;
        for (int k = 18; k <= 21; k++) begin
            tick();
            check_val($sformatf("sat_e%0d", k), out_s, sat_q[(k - 4) % 4]);
        end

        // Phase-continuous retune to a new frequency
        offer(2'd0, 32'h0123_4567, 32'h0, 16'd0, 32'h0, 12'd2048);
        tick();                               // E22
        cfg_valid = 1'b0;
        check_val("retune_acc0", dut.phase_acc_r, 64'h8000_0000);
        tick();
        check_val("retune_acc1", dut.phase_acc_r, 64'h8123_4567);
        tick();
        check_val("retune_acc2", dut.phase_acc_r, 64'h8246_8ACE);

        // stop and cfg_valid together: stop wins, nothing accepted
        stop = 1'b1;
        offer(2'd1, 32'h0, 32'h100, 16'd4, 32'h0, 12'd2048);
        #1;
        check_val("stop_ready", cfg_ready_s, 0);
        tick();
        check_val("stop_busy", busy_s, 0);
        check_val("stop_valid", out_valid_s, 0);
        check_val("stop_out", out_s, 0);
        check_val("stop_acc", dut.phase_acc_r, 0);
        check_val("stop_freq", dut.freq_r, 0);
        stop = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check_val("idle_ready", cfg_ready_s, 1);

        // One-shot sweep, N = 8, with an en-low freeze in the middle
        offer(2'd1, 32'h0, 32'h0010_0000, 16'd8, 32'h0, 12'd2048);
        tick();                               // S0
        cfg_valid = 1'b0;
        check_val("sw1_ready0", cfg_ready_s, 0);
        check_val("sw1_busy0", busy_s, 1);
        check_val("sw1_freq0", dut.freq_r, 0);
        check_val("sw1_cnt0", dut.cnt_r, 8);
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (sweep_done_s) done_cnt++;
            check_val($sformatf("sw1_freq_s%0d", k), dut.freq_r, longint'(k) << 20);
            check_val($sformatf("sw1_done_s%0d", k), sweep_done_s, (k == 8) ? 1 : 0);
            check_val($sformatf("sw1_ready_s%0d", k), cfg_ready_s, (k == 8) ? 1 : 0);
            if (k == 4) begin
                check_val("sw1_out_s4", out_s, 2);
                check_val("sw1_valid_s4", out_valid_s, 1);
                en = 1'b0;
                repeat (5) begin
                    tick();
                    if (sweep_done_s) done_cnt++;
                end
                check_val("frz_out", out_s, 2);
                check_val("frz_valid", out_valid_s, 1);
                check_val("frz_cnt", dut.cnt_r, 4);
                check_val("frz_freq", dut.freq_r, longint'(4) << 20);
                check_val("frz_acc", dut.phase_acc_r, longint'(6) << 20);
                en = 1'b1;
            end
        end
        tick();                               // S9, HOLD
        if (sweep_done_s) done_cnt++;
        check_val("sw1_done_count", done_cnt, 1);
        check_val("hold_freq", dut.freq_r, longint'(8) << 20);
        check_val("hold_ready", cfg_ready_s, 1);
        check_val("hold_busy", busy_s, 1);

        // Repeating sweep, N = 3
        offer(2'd2, 32'h0000_1000, 32'h0000_0100, 16'd3, 32'h0, 12'd2048);
        tick();                               // R0
        cfg_valid = 1'b0;
        check_val("sw2_freq0", dut.freq_r, 64'h1000);
        check_val("sw2_ready0", cfg_ready_s, 0);
        done_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (sweep_done_s) done_cnt++;
            check_val($sformatf("sw2_freq_r%0d", k), dut.freq_r, 64'h1000 + longint'(k % 3) * 64'h100);
            check_val($sformatf("sw2_done_r%0d", k), sweep_done_s, ((k % 3) == 0) ? 1 : 0);
        end
        check_val("sw2_done_count", done_cnt, 2);
        check_val("sw2_valid", out_valid_s, 1);

        // Asynchronous reset mid-sweep clears outputs at once
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_out", out_s, 0);
        check_val("arst_valid", out_valid_s, 0);
        check_val("arst_busy", busy_s, 0);
        check_val("arst_done", sweep_done_s, 0);
        check_val("arst_ready", cfg_ready_s, 1);
        check_val("arst_acc", dut.phase_acc_r, 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check_val("post_rst_valid", out_valid_s, 0);
        check_val("post_rst_busy", busy_s, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
